// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_pkg : command codes, operator encodings and BCD limits shared  |
// |            by key_entry and the downstream calculator. Rev 1.0      |
// +--------------------------------------------------------------------+
package calc_pkg;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_OPER   = 2'd1,
        CMD_EQUALS = 2'd2,
        CMD_CLEAR  = 2'd3
    } cmd_code_t;

    typedef enum logic [1:0] {
        OP_SUB  = 2'd0,
        OP_ADD  = 2'd1,
        OP_MUL  = 2'd2,
        OP_NONE = 2'd3
    } op_t;

    localparam logic [3:0] c_bcd_max_digit = 4'd9;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_debounce : 2-flop synchroniser, stability counter and one-cycle |
// |                press pulse for one active-low push-button. Rev 1.0  |
// +--------------------------------------------------------------------+
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    // Level flips to r_sync2, so a press is exactly a flip away from 1.
                    r_press <= r_level;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/key_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_entry : debounced keypad front-end building a BCD operand and   |
// |             issuing one-deep valid/ready calculator commands. Rev 1.0|
// +--------------------------------------------------------------------+
module key_entry
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DIGITS          = 6
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    input  logic [3:0]            KEY,
    input  logic [5:0]            SW,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_code,
    output logic [1:0]            cmd_op,
    output logic [4*DIGITS-1:0]   cmd_operand,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [2:0]            entry_count,
    output logic                  err_pulse
);

    localparam logic [2:0] c_digits = 3'(DIGITS);

    logic [3:0] w_press;
    logic       w_stall;
    logic       w_cmd_press;
    logic       w_digit_ok;

    logic                r_cmd_valid;
    cmd_code_t           r_cmd_code;
    op_t                 r_cmd_op;
    logic [4*DIGITS-1:0] r_cmd_operand;
    logic [4*DIGITS-1:0] r_entry;
    logic [2:0]          r_count;
    logic                r_err;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (CLOCK_50),
                .rst_n  (RST_N),
                .key_raw(KEY[i]),
                .press  (w_press[i])
            );
        end
    endgenerate

    assign w_stall     = r_cmd_valid & ~cmd_ready;
    assign w_cmd_press = |w_press[3:1];
    assign w_digit_ok  = (SW[3:0] <= c_bcd_max_digit) && (r_count < c_digits);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= CMD_NONE;
            r_cmd_op      <= OP_SUB;
            r_cmd_operand <= '0;
            r_entry       <= '0;
            r_count       <= '0;
            r_err         <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_cmd_valid && cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
            // A command key masks KEY[0] in the same cycle without flagging an error.
            if (w_cmd_press) begin
                if (w_stall) begin
                    r_err <= 1'b1;
                end else begin
                    r_cmd_valid <= 1'b1;
                    if (w_press[3]) begin
                        r_cmd_code    <= CMD_CLEAR;
                        r_cmd_op      <= OP_NONE;
                        r_cmd_operand <= '0;
                    end else if (w_press[2]) begin
                        r_cmd_code    <= CMD_EQUALS;
                        r_cmd_op      <= OP_NONE;
                        r_cmd_operand <= r_entry;
                    end else begin
                        r_cmd_code    <= CMD_OPER;
                        r_cmd_op      <= op_t'(SW[5:4]);
                        r_cmd_operand <= r_entry;
                    end
                    r_entry <= '0;
                    r_count <= '0;
                end
            end else if (w_press[0]) begin
                if (w_digit_ok) begin
                    r_entry <= {r_entry[4*DIGITS-5:0], SW[3:0]};
                    r_count <= r_count + 3'd1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign cmd_op      = r_cmd_op;
    assign cmd_operand = r_cmd_operand;
    assign entry_bcd   = r_entry;
    assign entry_count = r_count;
    assign err_pulse   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_key_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_key_entry : directed stimulus with a command/err scoreboard for  |
// |                key_entry at DEBOUNCE_CYCLES=4, DIGITS=6. Rev 1.0    |
// +--------------------------------------------------------------------+
module tb_key_entry;

    localparam int c_deb = 4;
    localparam int c_dig = 6;

    typedef struct {
        logic [1:0]  code;
        logic [1:0]  op;
        logic        chk_op;
        logic [23:0] operand;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key = 4'hF;
    logic [5:0]  sw = 6'd0;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_operand;
    logic [23:0] entry_bcd;
    logic [2:0]  entry_count;
    logic        err_pulse;

    int   checks = 0;
    int   errors = 0;
    int   err_expected = 0;
    cmd_t exp_q[$];

    always #5 clk = ~clk;

    key_entry #(
        .DEBOUNCE_CYCLES(c_deb),
        .DIGITS         (c_dig)
    ) dut (
        .CLOCK_50   (clk),
        .RST_N      (rst_n),
        .KEY        (key),
        .SW         (sw),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_op     (cmd_op),
        .cmd_operand(cmd_operand),
        .entry_bcd  (entry_bcd),
        .entry_count(entry_count),
        .err_pulse  (err_pulse)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_cmd(input logic [1:0] code, input logic [1:0] op,
                              input logic chk_op, input logic [23:0] operand);
        cmd_t c;
        c.code = code; c.op = op; c.chk_op = chk_op; c.operand = operand;
        exp_q.push_back(c);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] mask, input logic [5:0] s);
        sw  = s;
        key = ~mask;
        cycles(c_deb + 4);
        key = 4'hF;
        cycles(c_deb + 4);
    endtask

    // Monitor: consumes expected commands on each handshake and expected err pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_pulse) begin
                checks++;
                if (err_expected == 0) begin
                    errors++;
                    $display("FAIL err_pulse_unexpected: got 1 required 0");
                end else begin
                    err_expected--;
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: got code %0d required none", cmd_code);
                end else begin
                    cmd_t c;
                    c = exp_q.pop_front();
                    chk("cmd_code", 32'(cmd_code), 32'(c.code));
                    if (c.chk_op) chk("cmd_op", 32'(cmd_op), 32'(c.op));
                    chk("cmd_operand", 32'(cmd_operand), 32'(c.operand));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        cycles(2);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_entry", 32'(entry_bcd), 0);
        chk("rst_count", 32'(entry_count), 0);
        chk("rst_err", 32'(err_pulse), 0);
        rst_n = 1'b1;
        cycles(2);

        // Three-cycle glitch is ignored
        sw = 6'd7; key = 4'b1110;
        cycles(3);
        key = 4'hF;
        cycles(12);
        chk("glitch_count", 32'(entry_count), 0);

        // Exact press latency: 2 sync + 4 debounce + 1
        key = 4'b1110;
        cycles(6);
        chk("latency_early", 32'(entry_count), 0);
        cycles(1);
        chk("latency_count", 32'(entry_count), 1);
        chk("latency_entry", 32'(entry_bcd), 32'h7);
        key = 4'hF;
        cycles(8);

        expect_cmd(2'd3, 2'd0, 1'b0, 24'h0);
        press(4'b1000, 6'd0);
        chk("clear_entry", 32'(entry_bcd), 0);

        for (int d = 1; d <= 6; d++) press(4'b0001, 6'(d));
        chk("full_entry", 32'(entry_bcd), 32'h123456);
        chk("full_count", 32'(entry_count), 6);
        err_expected++;
        press(4'b0001, 6'd7);
        chk("overflow_entry", 32'(entry_bcd), 32'h123456);
        chk("overflow_count", 32'(entry_count), 6);

        expect_cmd(2'd2, 2'd3, 1'b1, 24'h123456);
        press(4'b0100, 6'd0);
        chk("equals_clear", 32'(entry_count), 0);

        press(4'b0001, 6'd4);
        press(4'b0001, 6'd2);
        err_expected++;
        press(4'b0001, 6'hA);
        chk("bad_digit_entry", 32'(entry_bcd), 32'h42);
        chk("bad_digit_count", 32'(entry_count), 2);

        // Stalled OPER
        cmd_ready = 1'b0;
        expect_cmd(2'd1, 2'd1, 1'b1, 24'h42);
        press(4'b0010, 6'h10);
        chk("oper_entry_cleared", 32'(entry_bcd), 0);
        chk("oper_count_cleared", 32'(entry_count), 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(cmd_valid), 1);
            chk("stall_operand", 32'(cmd_operand), 32'h42);
            chk("stall_op", 32'(cmd_op), 1);
            cycles(1);
        end
        press(4'b0001, 6'd5);
        chk("stall_digit", 32'(entry_bcd), 32'h5);
        err_expected++;
        press(4'b0100, 6'd0);
        chk("stall_drop_entry", 32'(entry_bcd), 32'h5);
        chk("stall_drop_code", 32'(cmd_code), 1);
        cmd_ready = 1'b1;
        cycles(1);
        chk("handshake_fall", 32'(cmd_valid), 0);

        // New command loading on the handshake cycle keeps valid high
        cmd_ready = 1'b0;
        expect_cmd(2'd2, 2'd3, 1'b1, 24'h5);
        press(4'b0100, 6'd0);
        chk("b2b_first_code", 32'(cmd_code), 2);
        expect_cmd(2'd3, 2'd0, 1'b0, 24'h0);
        sw = 6'd0; key = 4'b0111;
        cycles(6);
        cmd_ready = 1'b1;
        cycles(1);
        cmd_ready = 1'b0;
        chk("b2b_valid", 32'(cmd_valid), 1);
        chk("b2b_code", 32'(cmd_code), 3);
        key = 4'hF;
        cycles(8);
        cmd_ready = 1'b1;
        cycles(2);
        chk("b2b_drained", 32'(cmd_valid), 0);

        // KEY[3] and KEY[1] together
        press(4'b0001, 6'd8);
        expect_cmd(2'd3, 2'd0, 1'b0, 24'h0);
        press(4'b1010, 6'h10);
        chk("prio_entry", 32'(entry_bcd), 0);
        chk("prio_valid", 32'(cmd_valid), 0);

        // Reset with pending command and mid-debounce key
        press(4'b0001, 6'd9);
        cmd_ready = 1'b0;
        press(4'b0010, 6'h20);
        chk("pre_reset_valid", 32'(cmd_valid), 1);
        sw = 6'd3; key = 4'b1110;
        cycles(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(cmd_valid), 0);
        chk("async_rst_code", 32'(cmd_code), 0);
        chk("async_rst_op", 32'(cmd_op), 0);
        chk("async_rst_operand", 32'(cmd_operand), 0);
        chk("async_rst_entry", 32'(entry_bcd), 0);
        chk("async_rst_count", 32'(entry_count), 0);
        cycles(2);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        cycles(12);
        chk("held_key_count", 32'(entry_count), 1);
        chk("held_key_entry", 32'(entry_bcd), 32'h3);
        cycles(20);
        chk("held_key_single", 32'(entry_count), 1);
        key = 4'hF;
        cycles(10);
        chk("release_no_event", 32'(entry_count), 1);

        chk("cmd_queue_empty", 32'(exp_q.size()), 0);
        chk("err_all_seen", 32'(err_expected), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 The module SHALL expose parameter DEBOUNCE_CYCLES, default 500000, meaning the number of clock cycles a synchronised key level must be stable before it is accepted (10 ms at 50 MHz).
REQ-002 The module SHALL expose parameter DIGITS, default 6, meaning the number of BCD digits in the operand buffer.
REQ-003 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 KEY  input  4  raw push-buttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-006 SW  input  6  SW[3:0] digit value, SW[5:4] operator select.
REQ-007 cmd_valid  output  1  command word available.
REQ-008 cmd_ready  input  1  downstream calculator accepts the command this cycle.
REQ-009 cmd_code  output  2  command: DIGIT_NONE=0 (unused), OPER=1, EQUALS=2, CLEAR=3.
REQ-010 cmd_op  output  2  operator copied from SW[5:4] at OPER press (0 sub, 1 add, 2 mul, 3 none).
REQ-011 cmd_operand  output  4*DIGITS  BCD operand snapshot, digit 0 in bits [3:0].
REQ-012 entry_bcd  output  4*DIGITS  live operand buffer, for display.
REQ-013 entry_count  output  3  number of digits entered, 0..DIGITS.
REQ-014 err_pulse  output  1  one-cycle pulse on rejected input.

Function
REQ-015 Each KEY bit SHALL pass a 2-flop synchroniser, then a debouncer; the debounced level SHALL change only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch back SHALL restart the count from 0.
REQ-016 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; releases SHALL generate no event.
REQ-017 Press latency SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 cycles from stable KEY low to the resulting state change.
REQ-018 KEY[0] press with SW[3:0] <= 9 and entry_count < DIGITS SHALL shift SW[3:0] into digit 0, shift existing digits up by one, and increment entry_count.
REQ-019 KEY[0] press with SW[3:0] > 9 or entry_count == DIGITS SHALL leave the buffer unchanged and assert err_pulse.
REQ-020 KEY[1] press SHALL load the output register with code OPER, cmd_op = SW[5:4], cmd_operand = entry_bcd, then clear entry_bcd and entry_count in the same cycle.
REQ-021 KEY[2] press SHALL behave as REQ-020 with code EQUALS; cmd_op SHALL be 3.
REQ-022 KEY[3] press SHALL load code CLEAR, cmd_operand = 0, and clear the buffer.
REQ-023 Handshake: cmd_valid SHALL rise the cycle after a command press and hold, with cmd_code/cmd_op/cmd_operand stable, until the cycle cmd_valid && cmd_ready; it SHALL then fall unless a new command loads in that same cycle.
REQ-024 While cmd_valid && !cmd_ready, KEY[1..3] presses SHALL be dropped, the buffer left unchanged, and err_pulse asserted; KEY[0] presses SHALL still be accepted.
REQ-025 A command press in the same cycle as cmd_valid && cmd_ready SHALL load the new command and keep cmd_valid high.
REQ-026 Simultaneous press events SHALL be resolved by priority KEY[3] > KEY[2] > KEY[1] > KEY[0]; lower events SHALL be discarded with no err_pulse.
REQ-027 Output register SHALL be one entry deep; no FIFO.

Reset
REQ-028 RST_N low SHALL immediately clear: cmd_valid, cmd_code, cmd_op, cmd_operand, entry_bcd, entry_count, err_pulse, all debounce counters; synchroniser and debounced levels SHALL reset to 1 (released).
REQ-029 Reset mid-debounce or with a pending command SHALL discard it; a key held through reset release SHALL generate one press after the full debounce time.

Structure
REQ-030 Package calc_pkg SHALL hold cmd_code values, operator encodings and the 4-bit BCD max digit constant (9), shared with the calculator.
REQ-031 Sub-module key_debounce (synchroniser + counter + falling-edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated four times.

Verification
REQ-032 DEBOUNCE_CYCLES=4: KEY[0] pulsed low 3 cycles then high -> no change; held low 4 cycles with SW=7 -> entry_bcd=0x000007, entry_count=1.
REQ-033 Enter 1,2,3,4,5,6 then 7 -> entry_bcd=0x123456, count=6, seventh press gives err_pulse; SW=0xA press gives err_pulse, buffer unchanged.
REQ-034 Buffer 0x000042, SW[5:4]=1, KEY[1] with cmd_ready=0 for 5 cycles -> cmd_valid held, cmd_operand=0x000042, cmd_op=1; entry cleared; KEY[2] during stall -> err_pulse, dropped.
REQ-035 KEY[3] and KEY[1] pressed in same cycle -> single CLEAR command, no err_pulse.
REQ-036 RST_N low mid-debounce and with cmd_valid=1 -> all outputs 0 asynchronously; held key after release -> exactly one event.
